// File: rtl/encoder_ssi_transmitter_if.sv
// Position/status handshake and serial link signals
// for the encoder emulator.
interface encoder_ssi_transmitter_if #(
  parameter int POS_W = 19
);
  logic [POS_W-1:0] pos_in;
  logic             err_in;
  logic             warn_in;
  logic             pos_valid;
  logic             pos_ready;
  logic             miso;
  logic             busy;
  logic             frame_done;

  modport master (
    output pos_in,
    output err_in,
    output warn_in,
    output pos_valid,
    input  pos_ready,
    input  miso,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  pos_in,
    input  err_in,
    input  warn_in,
    input  pos_valid,
    output pos_ready,
    output miso,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/encoder_ssi_transmitter.sv
// Encoder-side serial transmitter: start bit, framed
// position/status word MSB first, idle-high gap.
module encoder_ssi_transmitter #(
  parameter int FRAME_W    = 24,
  parameter int POS_W      = 19,
  parameter int POS_LSB    = 3,
  parameter int GAP_CYCLES = 4,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                      sck,
  input  logic                      rst,
  encoder_ssi_transmitter_if.slave  link
);

  localparam int BW = $clog2(FRAME_W);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    GAP
  } state_t;

  state_t             state;
  logic [FRAME_W-1:0] word_q;
  logic [FRAME_W-1:0] word_d;
  logic [BW-1:0]      bit_cnt;
  logic               last_q;
  logic [GW-1:0]      gap_cnt;
  logic               miso_q;
  logic               done_q;
  logic               idle;
  logic               accept;
  logic               start;

  always_comb begin
    word_d = '0;
    word_d[POS_LSB +: POS_W] = link.pos_in;
    word_d[2] = link.err_in;
    word_d[1] = link.warn_in;
    word_d[0] = ^word_d[FRAME_W-1:1];
  end

  assign idle   = (state == IDLE);
  assign accept = idle && link.pos_valid;
  // a fresh word always wins over retransmit
  assign start  = accept || (idle && CONTINUOUS);

  assign link.pos_ready  = idle;
  assign link.busy       = !idle;
  assign link.miso       = miso_q;
  assign link.frame_done = done_q;

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      word_q  <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
      gap_cnt <= '0;
      miso_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (accept)
              word_q <= word_d;
            miso_q <= 1'b0;
            state  <= START;
          end else begin
            miso_q <= 1'b1;
          end
        end
        START: begin
          miso_q  <= word_q[FRAME_W-1];
          bit_cnt <= BW'(FRAME_W - 2);
          last_q  <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (last_q) begin
            miso_q  <= 1'b1;
            done_q  <= 1'b1;
            last_q  <= 1'b0;
            gap_cnt <= GW'(GAP_CYCLES - 1);
            // the high cycle of this edge already counts as gap
            state   <= (GAP_CYCLES > 1) ? GAP : IDLE;
          end else begin
            miso_q  <= word_q[bit_cnt];
            last_q  <= (bit_cnt == '0);
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        GAP: begin
          miso_q <= 1'b1;
          if (gap_cnt <= GW'(1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
